// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/redirect controller.
// Holds the FSM state encoding and the instruction/bubble constants
// that the front end loads when a stage is flushed.
package pipe_ctrl_pkg;

  // Controller states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPLAY = 2'd2
  } state_e;

  // Instruction loaded into if_id on a flush: addi x0, x0, 0.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Destination register written into id_ex on a bubble (paired with reg_wen=0).
  localparam logic [4:0] BUBBLE_RD = 5'd0;

  // Hold counter saturates here.
  localparam logic [7:0] HOLD_CNT_SAT = 8'hFF;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of the controller's stage-facing signals.
// The pipeline (master) drives hazard/redirect requests;
// the controller (slave) returns pc/if_id/id_ex control.
interface pipe_ctrl_if;

  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_req_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_reg_wen_i;
  logic        ex_is_load_i;
  logic        pc_load_o;
  logic [31:0] pc_load_addr_o;
  logic        pc_hold_o;
  logic        if_id_hold_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic        hold_timeout_o;

  modport master (
    output jump_en_i, jump_addr_i, hold_req_i,
    output id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, ex_reg_wen_i, ex_is_load_i,
    input  pc_load_o, pc_load_addr_o, pc_hold_o, if_id_hold_o,
    input  if_id_flush_o, id_ex_flush_o, hold_timeout_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, hold_req_i,
    input  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, ex_reg_wen_i, ex_is_load_i,
    output pc_load_o, pc_load_addr_o, pc_hold_o, if_id_hold_o,
    output if_id_flush_o, id_ex_flush_o, hold_timeout_o
  );

endinterface

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard detector: a load in ex feeds a source register read in id.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result is consumed by pipe_ctrl as a stall request.
module hazard_det (
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_reg_wen,
  input  logic       ex_is_load,
  output logic       hazard
);

  logic rd_nonzero;
  logic rd_match;

  // x0 never carries a real dependency, so it is excluded from the match.
  assign rd_nonzero = (ex_rd_addr != 5'd0);
  assign rd_match   = (ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr);
  assign hazard     = ex_is_load && ex_reg_wen && rd_nonzero && rd_match;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline front-end controller: redirects, multi-cycle holds and load-use stalls.
// Latency: control outputs are combinational in the request cycle; deferred jumps replay one cycle after a hold drops.
// Backpressure: hold_req_i freezes pc/if_id and bubbles id_ex until it drops; rst forces every output low.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [7:0] HOLD_MAX = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic        pend_valid_q;
  logic [31:0] pend_addr_q;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        timeout_q;

  logic        pend_set, pend_clr, cnt_clr, cnt_inc;
  logic        load_use;
  logic        pc_load, pc_hold, if_id_hold, if_id_flush, id_ex_flush;
  logic [31:0] pc_load_addr;

  hazard_det u_hazard_det (
    .id_rs1_addr (bus.id_rs1_addr_i),
    .id_rs2_addr (bus.id_rs2_addr_i),
    .ex_rd_addr  (bus.ex_rd_addr_i),
    .ex_reg_wen  (bus.ex_reg_wen_i),
    .ex_is_load  (bus.ex_is_load_i),
    .hazard      (load_use)
  );

  // Next state and per-cycle control; jump beats hold beats load-use in RUN.
  always_comb begin
    state_d      = state_q;
    pc_load      = 1'b0;
    pc_load_addr = 32'd0;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pend_set     = 1'b0;
    pend_clr     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.jump_en_i) begin
          pc_load      = 1'b1;
          pc_load_addr = bus.jump_addr_i;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
        end else if (bus.hold_req_i) begin
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
          cnt_clr     = 1'b1;
          state_d     = ST_HOLD;
        end else if (load_use) begin
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      ST_HOLD: begin
        // Only the first jump seen during a hold is kept; it is the older one.
        if (bus.jump_en_i && !pend_valid_q) begin
          pend_set = 1'b1;
        end
        if (bus.hold_req_i) begin
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
          cnt_inc     = 1'b1;
        end else begin
          state_d = (pend_valid_q || bus.jump_en_i) ? ST_REPLAY : ST_RUN;
        end
      end
      ST_REPLAY: begin
        pc_load      = 1'b1;
        pc_load_addr = pend_addr_q;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        pend_clr     = 1'b1;
        state_d      = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Hold counter: cleared on entry to HOLD, saturating count of held cycles.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (cnt_clr) begin
      hold_cnt_d = 8'd0;
    end else if (cnt_inc && (hold_cnt_q != HOLD_CNT_SAT)) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  // State, pending jump, hold counter and sticky timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 32'd0;
      hold_cnt_q   <= 8'd0;
      timeout_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      if (pend_set) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= bus.jump_addr_i;
      end else if (pend_clr) begin
        pend_valid_q <= 1'b0;
      end
      // Flag shows in the same cycle the counter reads HOLD_MAX.
      if ((cnt_clr || cnt_inc) && (hold_cnt_d == HOLD_MAX)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Reset masks every output regardless of the registered state.
  assign bus.pc_load_o      = pc_load && !rst;
  assign bus.pc_load_addr_o = (pc_load && !rst) ? pc_load_addr : 32'd0;
  assign bus.pc_hold_o      = pc_hold && !rst;
  assign bus.if_id_hold_o   = if_id_hold && !rst;
  assign bus.if_id_flush_o  = if_id_flush && !rst;
  assign bus.id_ex_flush_o  = id_ex_flush && !rst;
  assign bus.hold_timeout_o = timeout_q && !rst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: redirect, load-use, hold/replay, timeout and reset.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.HOLD_MAX(8'd3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Control vector order: {pc_load, pc_hold, if_id_hold, if_id_flush, id_ex_flush}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_JUMP  = 5'b10011;
  localparam logic [4:0] C_STALL = 5'b01101;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [4:0] ctl, input logic [31:0] addr);
    check({tag, "/ctl"}, {27'd0, bus.pc_load_o, bus.pc_hold_o, bus.if_id_hold_o,
                          bus.if_id_flush_o, bus.id_ex_flush_o}, {27'd0, ctl});
    check({tag, "/addr"}, bus.pc_load_addr_o, addr);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic jump, input logic [31:0] addr, input logic hold);
    bus.jump_en_i   = jump;
    bus.jump_addr_i = addr;
    bus.hold_req_i  = hold;
    #1;
  endtask

  task automatic set_ex(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic wen, input logic load);
    bus.id_rs1_addr_i = rs1;
    bus.id_rs2_addr_i = rs2;
    bus.ex_rd_addr_i  = rd;
    bus.ex_reg_wen_i  = wen;
    bus.ex_is_load_i  = load;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    tick();
    tick();

    // Outputs stay low in reset even with requests present.
    drive(1'b1, 32'h0000_0100, 1'b1);
    check_ctl("rst_req", C_NONE, 32'd0);
    check("rst_timeout", {31'd0, bus.hold_timeout_o}, 32'd0);
    tick();
    rst = 1'b0;

    // Redirect in RUN, then quiet.
    drive(1'b1, 32'h0000_0100, 1'b0);
    check_ctl("jump", C_JUMP, 32'h0000_0100);
    tick();
    drive(1'b0, 32'h0000_0100, 1'b0);
    check_ctl("jump_after", C_NONE, 32'd0);
    tick();

    // Load-use: one stall cycle, then ex holds a bubble.
    set_ex(5'd0, 5'd5, 5'd5, 1'b1, 1'b1);
    drive(1'b0, 32'd0, 1'b0);
    check_ctl("lu_rs2", C_STALL, 32'd0);
    tick();
    set_ex(5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    check_ctl("lu_after", C_NONE, 32'd0);
    tick();
    set_ex(5'd7, 5'd0, 5'd7, 1'b1, 1'b1);
    drive(1'b0, 32'd0, 1'b0);
    check_ctl("lu_rs1", C_STALL, 32'd0);
    tick();
    set_ex(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    drive(1'b0, 32'd0, 1'b0);
    check_ctl("lu_rd0", C_NONE, 32'd0);
    tick();
    set_ex(5'd0, 5'd5, 5'd5, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    check_ctl("lu_noload", C_NONE, 32'd0);
    tick();
    set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Four held cycles with two jumps; the first one replays.
    drive(1'b0, 32'd0, 1'b1);
    check_ctl("hold_c1", C_STALL, 32'd0);
    tick();
    drive(1'b1, 32'h0000_0200, 1'b1);
    check_ctl("hold_c2", C_STALL, 32'd0);
    tick();
    drive(1'b1, 32'h0000_0300, 1'b1);
    check_ctl("hold_c3", C_STALL, 32'd0);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    check_ctl("hold_c4", C_STALL, 32'd0);
    tick();
    drive(1'b0, 32'd0, 1'b0);
    check_ctl("hold_exit", C_NONE, 32'd0);
    tick();
    drive(1'b1, 32'h0000_0400, 1'b1);
    check_ctl("replay", C_JUMP, 32'h0000_0200);
    tick();
    drive(1'b0, 32'd0, 1'b0);
    check_ctl("replay_after", C_NONE, 32'd0);
    tick();

    // Timeout at HOLD_MAX=3: visible from the fifth held cycle, sticky until reset.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 32'd0, 1'b1);
      if (i == 1 || i == 4 || i == 5 || i == 10) begin
        check_ctl($sformatf("to_ctl_c%0d", i), C_STALL, 32'd0);
        check($sformatf("to_flag_c%0d", i), {31'd0, bus.hold_timeout_o}, (i >= 5) ? 32'd1 : 32'd0);
      end
      tick();
    end
    drive(1'b0, 32'd0, 1'b0);
    check_ctl("to_exit", C_NONE, 32'd0);
    check("to_flag_exit", {31'd0, bus.hold_timeout_o}, 32'd1);
    tick();
    check("to_flag_idle", {31'd0, bus.hold_timeout_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("to_flag_in_rst", {31'd0, bus.hold_timeout_o}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("to_flag_cleared", {31'd0, bus.hold_timeout_o}, 32'd0);
    tick();

    // Reset while holding with a pending jump: no replay afterwards.
    drive(1'b0, 32'd0, 1'b1);
    tick();
    drive(1'b1, 32'h0000_0500, 1'b1);
    check_ctl("rh_pend", C_STALL, 32'd0);
    tick();
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b1);
    check_ctl("rh_in_rst", C_NONE, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    check_ctl("rh_rel1", C_NONE, 32'd0);
    tick();
    drive(1'b0, 32'd0, 1'b0);
    check_ctl("rh_rel2", C_NONE, 32'd0);
    tick();

    // Jump and hold together in RUN: redirect wins, no HOLD entered.
    drive(1'b1, 32'h0000_0600, 1'b1);
    check_ctl("jh_both", C_JUMP, 32'h0000_0600);
    tick();
    drive(1'b0, 32'd0, 1'b0);
    check_ctl("jh_after", C_NONE, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
